// File: rtl/bicubic_line_ctrl.sv
// rtl/bicubic_line_ctrl.sv - edge-padding line sequencer and credit-gated result FIFO for the bicubic core (BICUBIC_STALL_CNT_EN adds stall_cnt)
module bicubic_line_ctrl #(
    parameter int LINE_W     = 16,
    parameter int CORE_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        core_act,
    output logic [7:0]  core_in,
    input  logic [7:0]  core_out_0,
    input  logic [7:0]  core_out_1,
    input  logic [7:0]  core_out_2,
    input  logic [7:0]  core_out_3,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        done
`ifdef BICUBIC_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int J_W = $clog2(LINE_W + 3);
    localparam int R_W = $clog2(LINE_W);
    localparam int A_W = $clog2(FIFO_DEPTH);
    localparam int C_W = A_W + 1;
    localparam int S_W = C_W + 1;
    localparam int F_W = $clog2(CORE_LAT + 1);
    localparam logic [J_W-1:0] J_WARM       = J_W'(3);
    localparam logic [J_W-1:0] J_LAST_PIX   = J_W'(LINE_W);
    localparam logic [J_W-1:0] J_LAST_ISSUE = J_W'(LINE_W + 2);
    localparam logic [R_W-1:0] R_LAST       = R_W'(LINE_W - 1);

    typedef enum logic [2:0] {IDLE, PAD_L, FEED, PAD_R, DRAIN} state_t;

    state_t              state, state_nx;
    logic [J_W-1:0]      j;
    logic [7:0]          last_pix;
    logic [7:0]          core_in_q;
    logic [7:0]          issue_pix;
    logic [CORE_LAT-1:0] vsr;
    logic [F_W-1:0]      inflight;
    logic [31:0]         mem_data [FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];
    logic [A_W-1:0]      wr_ptr, rd_ptr;
    logic [C_W-1:0]      fifo_count;
    logic [R_W-1:0]      wr_idx;
    logic                last_acc;
    logic                credit_ok, warm, issue, counted, accept_start, stall;
    logic                fifo_wr, fifo_rd;

    // Number of counted issues still travelling through the core
    always_comb begin
        inflight = '0;
        for (int i = 0; i < CORE_LAT; i++) begin
            inflight = inflight + F_W'(vsr[i]);
        end
    end

    assign credit_ok = ({1'b0, fifo_count} + S_W'(inflight)) < S_W'(FIFO_DEPTH);
    assign warm      = j < J_WARM;

    // Next state, issue decision and handshake outputs
    always_comb begin
        state_nx     = state;
        s_ready      = 1'b0;
        issue        = 1'b0;
        issue_pix    = last_pix;
        stall        = 1'b0;
        done         = 1'b0;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nx     = PAD_L;
                end
            end
            PAD_L: begin
                // Left pad: peek p0 without consuming it
                if (s_valid) begin
                    issue     = 1'b1;
                    issue_pix = s_data;
                    state_nx  = FEED;
                end
            end
            FEED: begin
                s_ready = credit_ok | warm;
                if (s_valid && s_ready) begin
                    issue     = 1'b1;
                    issue_pix = s_data;
                    if (j == J_LAST_PIX) begin
                        state_nx = PAD_R;
                    end
                end else if (s_valid) begin
                    stall = 1'b1;
                end
            end
            PAD_R: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (j == J_LAST_ISSUE) begin
                        state_nx = DRAIN;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            DRAIN: begin
                if (last_acc && inflight == '0 && fifo_count == '0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign counted  = issue && !warm;
    assign core_act = issue;
    assign core_in  = issue ? issue_pix : core_in_q;
    assign busy     = state != IDLE;
    assign fifo_wr  = vsr[CORE_LAT-1];
    assign m_valid  = fifo_count != '0;
    assign fifo_rd  = m_valid && m_ready;
    assign m_data   = m_valid ? mem_data[rd_ptr] : 32'h0;
    assign m_last   = m_valid && mem_last[rd_ptr];

    // Sequencer state, issue index, pad pixel and in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            last_pix  <= 8'h0;
            core_in_q <= 8'h0;
            vsr       <= '0;
            wr_idx    <= '0;
            last_acc  <= 1'b0;
        end else begin
            state     <= state_nx;
            core_in_q <= core_in;
            vsr[0]    <= counted;
            for (int i = 1; i < CORE_LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
            if (accept_start) begin
                j        <= '0;
                wr_idx   <= '0;
                last_acc <= 1'b0;
            end else begin
                if (issue) begin
                    j        <= j + 1'b1;
                    last_pix <= issue_pix;
                end
                if (fifo_wr) begin
                    wr_idx <= wr_idx + 1'b1;
                end
                if (fifo_rd && m_last) begin
                    last_acc <= 1'b1;
                end
            end
        end
    end

    // Result FIFO storage; the head slot is read before being overwritten
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data[wr_ptr] <= {core_out_3, core_out_2, core_out_1, core_out_0};
            mem_last[wr_ptr] <= (wr_idx == R_LAST);
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef BICUBIC_STALL_CNT_EN
    // Saturating count of cycles an issue waited on credit
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            stall_cnt <= 16'h0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bicubic_line_ctrl.sv
// tb/tb_bicubic_line_ctrl.sv - directed self-checking bench for bicubic_line_ctrl
module tb_bicubic_line_ctrl;
    localparam int N = 6;
    localparam int LAT = 3;
    localparam int DEPTH = 4;

    localparam logic [47:0]  P1 = 48'h3C32281E140A;
    localparam logic [191:0] E1 = {32'h3C3C3C32, 32'h3C3C3228, 32'h3C32281E,
                                   32'h32281E14, 32'h281E140A, 32'h1E140A0A};
    localparam logic [47:0]  P3 = 48'h13110D0B0705;
    localparam logic [191:0] E3 = {32'h13131311, 32'h1313110D, 32'h13110D0B,
                                   32'h110D0B07, 32'h0D0B0705, 32'h0B070505};
    localparam logic [47:0]  P4 = 48'h605F5E5D5C5B;
    localparam logic [47:0]  P5 = 48'h060504030201;
    localparam logic [191:0] E5 = {32'h06060605, 32'h06060504, 32'h06050403,
                                   32'h05040302, 32'h04030201, 32'h03020101};

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready, core_act, m_valid, m_ready, m_last, busy, done;
    logic [7:0]  s_data, core_in, core_out_0, core_out_1, core_out_2, core_out_3;
    logic [31:0] m_data;
`ifdef BICUBIC_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int vectors = 0;
    int errs = 0;
    int cyc = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
    int outstanding = 0, line_acts = 0, pidx = 0;
    bit sd;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    logic [7:0]  pix [N];
    logic [7:0]  act_q [$];
    logic [31:0] beat_q [$];
    logic        last_q [$];

    always #5 clk = ~clk;

    bicubic_line_ctrl #(.LINE_W(N), .CORE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_act(core_act), .core_in(core_in),
        .core_out_0(core_out_0), .core_out_1(core_out_1),
        .core_out_2(core_out_2), .core_out_3(core_out_3),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
`ifdef BICUBIC_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Core stand-in: 4-tap window shifted on core_act, outputs delayed LAT cycles
    logic [7:0]  w1 = 8'h0, w2 = 8'h0, w3 = 8'h0;
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (core_act) begin
            w1 <= w2;
            w2 <= w3;
            w3 <= core_in;
        end
        pipe[0] <= {core_in, w3, w2, w1};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {core_out_3, core_out_2, core_out_1, core_out_0} = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: records issues and beats, checks hold and credit bound
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            outstanding = 0;
            line_acts = 0;
            prev_stall = 0;
        end else begin
            if (start && !busy) line_acts = 0;
            if (core_act) begin
                act_q.push_back(core_in);
                if (line_acts >= 3) outstanding++;
                line_acts++;
            end
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                if (m_last) last_cyc = cyc;
                outstanding--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) check("hold_m_data", m_data, prev_data);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            check("credit_bound", 32'(outstanding <= DEPTH), 32'd1);
        end
    end

    task automatic set_pix(input logic [47:0] px);
        for (int i = 0; i < N; i++) pix[i] = px[i*8 +: 8];
    endtask

    task automatic clear_obs();
        act_q.delete();
        beat_q.delete();
        last_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        pidx = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input int cycles, input bit rnd_v, input bit tog, output bit saw_done);
        bit hs;
        saw_done = 0;
        for (int c = 0; c < cycles && !saw_done; c++) begin
            s_valid = (pidx < N) && (rnd_v ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (pidx < N) s_data = pix[pidx];
            if (tog) m_ready = ~m_ready;
            @(negedge clk);
            hs = s_valid && s_ready;
            if (done) saw_done = 1;
            @(posedge clk); #1;
            if (hs) pidx++;
        end
        s_valid = 1'b0;
    endtask

    task automatic check_line(input logic [47:0] px, input logic [191:0] eb, input string tag);
        logic [7:0] ea [N+3];
        ea[0] = px[7:0];
        for (int i = 0; i < N; i++) ea[i+1] = px[i*8 +: 8];
        ea[N+1] = px[(N-1)*8 +: 8];
        ea[N+2] = px[(N-1)*8 +: 8];
        check({tag, "_nacts"}, act_q.size(), N + 3);
        for (int i = 0; i < act_q.size() && i < N + 3; i++)
            check($sformatf("%s_act%0d", tag, i), act_q[i], ea[i]);
        check({tag, "_nbeats"}, beat_q.size(), N);
        for (int i = 0; i < beat_q.size() && i < N; i++) begin
            check($sformatf("%s_beat%0d", tag, i), beat_q[i], eb[i*32 +: 32]);
            check($sformatf("%s_last%0d", tag, i), last_q[i], i == N - 1);
        end
        check({tag, "_ndone"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc, last_cyc + 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_core_act"}, core_act, 0);
        check({tag, "_core_in"}, core_in, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Line at full downstream rate
        set_pix(P1); clear_obs(); pulse_start();
        drive(80, 0, 0, sd);
        check("l1_done_seen", sd, 1);
        check_line(P1, E1, "l1");

        // Downstream stalled: credit caps the counted issues at FIFO depth
        m_ready = 1'b0; clear_obs(); pulse_start();
        drive(25, 0, 0, sd);
        check("l2_no_done", sd, 0);
        check("l2_stalled_acts", act_q.size(), 7);
        check("l2_no_beats", beat_q.size(), 0);
        check("l2_m_valid", m_valid, 1);
        check("l2_head", m_data, E1[31:0]);
        check("l2_core_act_idle", core_act, 0);
        check("l2_busy", busy, 1);
`ifdef BICUBIC_STALL_CNT_EN
        check("l2_stall_cnt_nz", stall_cnt != 16'h0, 1);
`endif
        m_ready = 1'b1;
        drive(80, 0, 0, sd);
        check("l2_done_seen", sd, 1);
        check_line(P1, E1, "l2");

        // Random s_valid with m_ready toggling every cycle
        set_pix(P3); clear_obs(); pulse_start();
        drive(200, 1, 1, sd);
        m_ready = 1'b1;
        check("l3_done_seen", sd, 1);
        check_line(P3, E3, "l3");

        // Reset mid-FEED after five pixels, then a fresh line
        set_pix(P4); clear_obs(); pulse_start();
        drive(6, 0, 0, sd);
        check("l4_consumed", pidx, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst1");
        rst = 1'b0;
        clear_obs();
        repeat (8) @(posedge clk);
        #1;
        check("l4_no_stale_valid", m_valid, 0);
        check("l4_no_stale_beats", beat_q.size(), 0);
        check("l4_no_stale_acts", act_q.size(), 0);
        set_pix(P5); clear_obs(); pulse_start();
        drive(80, 0, 0, sd);
        check("l5_done_seen", sd, 1);
        check_line(P5, E5, "l5");

        // Second start while busy, with s_valid held low for ten cycles
        set_pix(P1); clear_obs(); pulse_start();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("l6_no_acts", act_q.size(), 0);
        check("l6_core_act", core_act, 0);
        check("l6_busy", busy, 1);
        drive(80, 0, 0, sd);
        check("l6_done_seen", sd, 1);
        check_line(P1, E1, "l6");

        // Back-to-back lines: second start in the cycle after done
        clear_obs(); pulse_start();
        drive(80, 0, 0, sd);
        check("b1_done_seen", sd, 1);
        check_line(P1, E1, "b1");
        set_pix(P5); clear_obs(); pulse_start();
        drive(80, 0, 0, sd);
        check("b2_done_seen", sd, 1);
        check_line(P5, E5, "b2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
